// File: rtl/kronos_hcu_pkg.sv
// Shared constants and types for the Kronos hazard control unit.
package kronos_hcu_pkg;

    localparam int HCU_NREG = 32;

    typedef logic [4:0] regidx_t;

endpackage

// File: rtl/kronos_hcu_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, x0 never tracked.
module kronos_hcu_scoreboard
    import kronos_hcu_pkg::*;
#(
    parameter int NREG = HCU_NREG
) (
    input  logic            clk,
    input  logic            rstz,
    input  logic            set_vld,
    input  regidx_t         set_idx,
    input  logic            wb_vld,
    input  regidx_t         wb_rd,
    input  logic            flush,
    output logic [NREG-1:0] busy,
    output logic [NREG-1:0] free
);

    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_vld && (set_idx != '0)) set_mask[set_idx] = 1'b1;
        if (wb_vld) clr_mask[wb_rd] = 1'b1;
    end

    // A retiring write frees its register in the same cycle.
    always_comb begin
        free    = ~busy | clr_mask;
        free[0] = 1'b1;
    end

    // Set is applied after clear so a same-cycle set/clear leaves the bit set.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

endmodule

// File: rtl/kronos_hcu.sv
// Hazard control unit between ID and EX: gates the handshake on scoreboard state
// and counts stalled cycles.
module kronos_hcu
    import kronos_hcu_pkg::*;
#(
    parameter int NREG  = HCU_NREG,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstz,
    input  logic             id_vld,
    output logic             id_rdy,
    input  regidx_t          id_rs1,
    input  regidx_t          id_rs2,
    input  logic             id_rs1_rd,
    input  logic             id_rs2_rd,
    input  regidx_t          id_rd,
    input  logic             id_rd_write,
    output logic             ex_vld,
    input  logic             ex_rdy,
    input  logic             wb_vld,
    input  regidx_t          wb_rd,
    input  logic             flush,
    output logic             stall,
    output logic [NREG-1:0]  busy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [NREG-1:0] free;
    logic            hazard;
    logic            issue;

    kronos_hcu_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk     (clk),
        .rstz    (rstz),
        .set_vld (issue & id_rd_write),
        .set_idx (id_rd),
        .wb_vld  (wb_vld),
        .wb_rd   (wb_rd),
        .flush   (flush),
        .busy    (busy),
        .free    (free)
    );

    // The rd term blocks WAW, so a single busy bit per register is enough.
    always_comb begin
        hazard = (id_rs1_rd   & ~free[id_rs1])
               | (id_rs2_rd   & ~free[id_rs2])
               | (id_rd_write & ~free[id_rd]);
        ex_vld = id_vld & ~hazard & ~flush;
        id_rdy = ex_rdy & ~hazard & ~flush;
        issue  = ex_vld & ex_rdy;
        stall  = id_vld & hazard & ~flush;
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_kronos_hcu.sv
// Directed self-checking bench for kronos_hcu; a second instance with a 4-bit
// counter shares the same stimulus to exercise saturation.
`timescale 1ns/1ps
module tb_kronos_hcu;
    import kronos_hcu_pkg::*;

    logic        clk = 1'b0;
    logic        rstz = 1'b0;
    logic        id_vld = 1'b0;
    regidx_t     id_rs1 = '0;
    regidx_t     id_rs2 = '0;
    logic        id_rs1_rd = 1'b0;
    logic        id_rs2_rd = 1'b0;
    regidx_t     id_rd = '0;
    logic        id_rd_write = 1'b0;
    logic        ex_rdy = 1'b1;
    logic        wb_vld = 1'b0;
    regidx_t     wb_rd = '0;
    logic        flush = 1'b0;

    logic        id_rdy, ex_vld, stall;
    logic [31:0] busy;
    logic [15:0] stall_cnt;
    logic        id_rdy4, ex_vld4, stall4;
    logic [31:0] busy4;
    logic [3:0]  stall_cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    kronos_hcu #(.NREG(32), .CNT_W(16)) dut (
        .clk(clk), .rstz(rstz), .id_vld(id_vld), .id_rdy(id_rdy),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_rd(id_rs1_rd), .id_rs2_rd(id_rs2_rd),
        .id_rd(id_rd), .id_rd_write(id_rd_write), .ex_vld(ex_vld), .ex_rdy(ex_rdy),
        .wb_vld(wb_vld), .wb_rd(wb_rd), .flush(flush), .stall(stall),
        .busy(busy), .stall_cnt(stall_cnt)
    );

    kronos_hcu #(.NREG(32), .CNT_W(4)) dut4 (
        .clk(clk), .rstz(rstz), .id_vld(id_vld), .id_rdy(id_rdy4),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_rd(id_rs1_rd), .id_rs2_rd(id_rs2_rd),
        .id_rd(id_rd), .id_rd_write(id_rd_write), .ex_vld(ex_vld4), .ex_rdy(ex_rdy),
        .wb_vld(wb_vld), .wb_rd(wb_rd), .flush(flush), .stall(stall4),
        .busy(busy4), .stall_cnt(stall_cnt4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input regidx_t rs1, input logic r1rd,
                         input regidx_t rs2, input logic r2rd,
                         input regidx_t rd, input logic rdw);
        id_vld = vld;  id_rs1 = rs1; id_rs1_rd = r1rd;
        id_rs2 = rs2;  id_rs2_rd = r2rd;
        id_rd = rd;    id_rd_write = rdw;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic retire(input regidx_t r);
        idle();
        wb_vld = 1'b1; wb_rd = r;
        tick();
        wb_vld = 1'b0; wb_rd = '0;
    endtask

    initial begin
        // reset
        #12;
        check("rst_busy", busy, 32'h0);
        check("rst_cnt", {16'h0, stall_cnt}, 32'h0);
        check("rst_ex_vld", {31'h0, ex_vld}, 32'h0);
        check("rst_id_rdy", {31'h0, id_rdy}, 32'h1);
        rstz = 1'b1;
        tick();

        // 1: issue ADD rd=5
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1);
        check("t1_ex_vld", {31'h0, ex_vld}, 32'h1);
        check("t1_stall", {31'h0, stall}, 32'h0);
        tick();
        idle();
        check("t1_busy", busy, 32'h0000_0020);

        // 2: RAW on x5, released by same-cycle retire
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
        check("t2_stall", {31'h0, stall}, 32'h1);
        check("t2_ex_vld", {31'h0, ex_vld}, 32'h0);
        check("t2_id_rdy", {31'h0, id_rdy}, 32'h0);
        tick();
        check("t2_stall_hold", {31'h0, stall}, 32'h1);
        wb_vld = 1'b1; wb_rd = 5'd5;
        #1;
        check("t2_bypass_ex_vld", {31'h0, ex_vld}, 32'h1);
        check("t2_bypass_stall", {31'h0, stall}, 32'h0);
        tick();
        wb_vld = 1'b0;
        idle();
        check("t2_busy_reset", busy, 32'h0000_0020);
        check("t2_cnt", {16'h0, stall_cnt}, 32'd1);
        retire(5'd5);
        check("t2_busy_clr", busy, 32'h0);

        // 3: x0 is never tracked
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            check("t3_ex_vld", {31'h0, ex_vld}, 32'h1);
            check("t3_stall", {31'h0, stall}, 32'h0);
            tick();
        end
        idle();
        check("t3_busy", busy, 32'h0);
        check("t3_cnt", {16'h0, stall_cnt}, 32'd1);

        // 4: flush clears busy, ignores wb, blocks issue
        for (int r = 8; r < 12; r++) begin
            drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, regidx_t'(r), 1'b1);
            tick();
        end
        idle();
        check("t4_busy_pre", busy, 32'h0000_0F00);
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1);
        flush = 1'b1; wb_vld = 1'b1; wb_rd = 5'd9;
        #1;
        check("t4_flush_ex_vld", {31'h0, ex_vld}, 32'h0);
        check("t4_flush_id_rdy", {31'h0, id_rdy}, 32'h0);
        check("t4_flush_stall", {31'h0, stall}, 32'h0);
        tick();
        flush = 1'b0; wb_vld = 1'b0;
        drive(1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0);
        check("t4_busy_post", busy, 32'h0);
        check("t4_issue", {31'h0, ex_vld}, 32'h1);
        check("t4_no_stall", {31'h0, stall}, 32'h0);
        tick();
        idle();

        // 5: WAW on x7
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        tick();
        idle();
        check("t5_busy", busy, 32'h0000_0080);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("t5_stall", {31'h0, stall}, 32'h1);
            tick();
        end
        wb_vld = 1'b1; wb_rd = 5'd7;
        #1;
        check("t5_release", {31'h0, ex_vld}, 32'h1);
        tick();
        wb_vld = 1'b0;
        idle();
        check("t5_cnt", {16'h0, stall_cnt}, 32'd4);
        check("t5_busy_reset", busy, 32'h0000_0080);
        retire(5'd3);
        check("t5_stray_wb", busy, 32'h0000_0080);

        // 6: 20-cycle hazard saturates the 4-bit counter
        drive(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        check("t6_cnt16", {16'h0, stall_cnt}, 32'd24);
        check("t6_cnt4_sat", {28'h0, stall_cnt4}, 32'hF);
        check("t6_busy4", busy4, 32'h0000_0080);
        retire(5'd7);

        // random backpressure: ex_vld held, id_rdy follows ex_rdy
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            ex_rdy = 1'($urandom_range(0, 1));
            #1;
            check("t6_bp_ex_vld", {31'h0, ex_vld}, 32'h1);
            check("t6_bp_id_rdy", {31'h0, id_rdy}, {31'h0, ex_rdy});
            tick();
        end
        ex_rdy = 1'b1;
        idle();

        // asynchronous reset mid-operation
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1);
        tick();
        idle();
        check("t7_busy_pre", busy, 32'h0010_0000);
        #2;
        rstz = 1'b0;
        #1;
        check("t7_rst_busy", busy, 32'h0);
        check("t7_rst_cnt", {16'h0, stall_cnt}, 32'h0);
        check("t7_rst_cnt4", {28'h0, stall_cnt4}, 32'h0);
        tick();
        rstz = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
